// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the master-side bridges.
package ahb_pkg;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HsizeByte = 3'b000,
        HsizeHalf = 3'b001,
        HsizeWord = 3'b010
    } hsize_t;

    typedef enum logic [2:0] {
        HburstSingle = 3'b000,
        HburstIncr   = 3'b001
    } hburst_t;

    typedef enum logic {
        HrespOkay  = 1'b0,
        HrespError = 1'b1
    } hresp_t;

endpackage

// File: rtl/generic_bus_if.sv
// Simple single-outstanding request bus between the memory arbiter and a bus bridge.
interface generic_bus_if;

    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic        busy;
    logic [31:0] rdata;

    modport generic_bus (
        input  ren, wen, addr, wdata, byte_en,
        output busy, rdata
    );

    modport cpu (
        output ren, wen, addr, wdata, byte_en,
        input  busy, rdata
    );

endinterface

// File: rtl/ahb_size_decode.sv
// Byte-enable to HSIZE/HADDR translation for AHB-Lite masters.
module ahb_size_decode
    import ahb_pkg::*;
(
    input  logic [3:0]  byte_en,
    input  logic [31:0] addr,
    output hsize_t      hsize,
    output logic [31:0] haddr
);

    logic [1:0] addr_lo;
    // Low address bits come from the lane pattern, never from the request.
    logic       unused_addr_lo;

    assign unused_addr_lo = ^addr[1:0];

    always_comb begin
        hsize   = HsizeWord;
        addr_lo = 2'b00;
        case (byte_en)
            4'b1111: begin hsize = HsizeWord; addr_lo = 2'b00; end
            4'b0011: begin hsize = HsizeHalf; addr_lo = 2'b00; end
            4'b1100: begin hsize = HsizeHalf; addr_lo = 2'b10; end
            4'b0001: begin hsize = HsizeByte; addr_lo = 2'b00; end
            4'b0010: begin hsize = HsizeByte; addr_lo = 2'b01; end
            4'b0100: begin hsize = HsizeByte; addr_lo = 2'b10; end
            4'b1000: begin hsize = HsizeByte; addr_lo = 2'b11; end
            // Irregular lane patterns fall back to a full word access.
            default: begin hsize = HsizeWord; addr_lo = 2'b00; end
        endcase
    end

    assign haddr = {addr[31:2], addr_lo};

endmodule

// File: rtl/generic_bus_ahb_master.sv
// Single-outstanding bridge from generic_bus_if to an AHB-Lite master port.
module generic_bus_ahb_master
    import ahb_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                   CLK,
    input  logic                   nRST,
    generic_bus_if.generic_bus     gen_bus_if,
    output logic [31:0]            HADDR,
    output logic [1:0]             HTRANS,
    output logic                   HWRITE,
    output logic [2:0]             HSIZE,
    output logic [2:0]             HBURST,
    output logic [3:0]             HPROT,
    output logic [31:0]            HWDATA,
    input  logic [31:0]            HRDATA,
    input  logic                   HREADY,
    input  logic                   HRESP,
    output logic                   bus_error
);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StErr
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  byte_en_q;
    logic        write_q;
    logic        capture;
    logic        busy;
    logic [31:0] rdata;
    htrans_t     htrans;
    hsize_t      hsize;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StIdle;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            byte_en_q <= 4'hF;
            write_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q    <= gen_bus_if.addr;
                wdata_q   <= gen_bus_if.wdata;
                byte_en_q <= gen_bus_if.byte_en;
                write_q   <= gen_bus_if.wen;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        busy      = 1'b1;
        rdata     = 32'h0;
        bus_error = 1'b0;
        htrans    = HtransIdle;
        unique case (state_q)
            StIdle: begin
                if (gen_bus_if.ren || gen_bus_if.wen) begin
                    capture = 1'b1;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                htrans = HtransNonseq;
                if (HREADY) begin
                    state_d = StData;
                end
            end
            StData: begin
                // A single-cycle ERROR still completes, but is flagged.
                if (HREADY) begin
                    busy      = 1'b0;
                    rdata     = HRDATA;
                    bus_error = HRESP;
                    state_d   = StIdle;
                end else if (HRESP) begin
                    state_d = StErr;
                end
            end
            StErr: begin
                if (HREADY) begin
                    busy      = 1'b0;
                    bus_error = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    ahb_size_decode u_size_decode (
        .byte_en (byte_en_q),
        .addr    (addr_q),
        .hsize   (hsize),
        .haddr   (HADDR)
    );

    assign HTRANS           = htrans;
    assign HSIZE            = hsize;
    assign HWRITE           = write_q;
    assign HWDATA           = wdata_q;
    assign HBURST           = HburstSingle;
    assign HPROT            = HPROT_VAL;
    assign gen_bus_if.busy  = busy;
    assign gen_bus_if.rdata = rdata;

endmodule
